// File: rtl/mouse_move_cmd_if.sv
// Button-in / command-out bundle between the mouse front end and the player movement controller.
// The master drives vsync and the raw button levels; the slave returns the command pulses.
interface mouse_move_cmd_if;
   logic v_tick;
   logic m_left;
   logic m_right;
   logic move_left;
   logic move_right;
   logic jump;
   logic repeat_active;

   modport master (
      output v_tick, m_left, m_right,
      input  move_left, move_right, jump, repeat_active
   );

   modport slave (
      input  v_tick, m_left, m_right,
      output move_left, move_right, jump, repeat_active
   );
endinterface

// File: rtl/mouse_move_cmd.sv
// Synchronises and debounces the mouse buttons, then turns them into one-cycle move/jump pulses
// with frame-paced auto-repeat for held buttons.
module mouse_move_cmd #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 40000,
   parameter int REPEAT_DELAY    = 15,
   parameter int REPEAT_RATE     = 4
) (
   input logic             clk,
   input logic             rst,
   mouse_move_cmd_if.slave bus
);

   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int FC_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

   logic [SYNC_STAGES-1:0] sync_l, sync_r;
   logic [1:0]             btn_sync;   // index 0 = left, 1 = right
   logic [1:0]             btn_db;
   logic [DB_W-1:0]        db_cnt [2];
   logic                   v_prev, frame_tick;

   state_t                 state, state_n;
   logic                   dir, dir_n;  // 0 = left, 1 = right
   logic [FC_W-1:0]        frame_cnt, frame_cnt_n, cnt_inc, cnt_target;
   logic                   move_left_q, move_right_q, jump_q;
   logic                   move_left_n, move_right_n, jump_n;
   logic                   held, btn_l, btn_r;

   assign btn_sync = {sync_r[SYNC_STAGES-1], sync_l[SYNC_STAGES-1]};

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_l     <= '0;
         sync_r     <= '0;
         btn_db     <= '0;
         db_cnt[0]  <= '0;
         db_cnt[1]  <= '0;
         v_prev     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         sync_l     <= {sync_l[SYNC_STAGES-2:0], bus.m_left};
         sync_r     <= {sync_r[SYNC_STAGES-2:0], bus.m_right};
         v_prev     <= bus.v_tick;
         frame_tick <= bus.v_tick & ~v_prev;
         for (int i = 0; i < 2; i++) begin
            if (btn_sync[i] == btn_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               btn_db[i] <= btn_sync[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn_l      = btn_db[0];
   assign btn_r      = btn_db[1];
   assign held       = dir ? btn_r : btn_l;
   assign cnt_inc    = (frame_cnt == FC_W'(CNT_MAX)) ? frame_cnt : frame_cnt + 1'b1;
   assign cnt_target = (state == HOLD) ? FC_W'(REPEAT_DELAY) : FC_W'(REPEAT_RATE);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n      = state;
      dir_n        = dir;
      frame_cnt_n  = frame_cnt;
      move_left_n  = 1'b0;
      move_right_n = 1'b0;
      jump_n       = 1'b0;
      case (state)
         IDLE: begin
            if (btn_l && btn_r) begin
               jump_n  = 1'b1;
               state_n = LOCK;
            end else if (btn_l || btn_r) begin
               move_left_n  = btn_l;
               move_right_n = btn_r;
               dir_n        = btn_r;
               frame_cnt_n  = '0;
               state_n      = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (!btn_l && !btn_r) begin
               state_n = IDLE;
            end else if (btn_l && btn_r) begin
               jump_n  = 1'b1;
               state_n = LOCK;
            end else if (!held) begin
               // Swap: restart the delay for the new direction; any tick this cycle is dropped.
               move_left_n  = btn_l;
               move_right_n = btn_r;
               dir_n        = ~dir;
               frame_cnt_n  = '0;
               state_n      = HOLD;
            end else if (frame_tick) begin
               if (cnt_inc == cnt_target) begin
                  move_left_n  = ~dir;
                  move_right_n = dir;
                  frame_cnt_n  = '0;
                  state_n      = REPEAT;
               end else begin
                  frame_cnt_n = cnt_inc;
               end
            end
         end
         LOCK: begin
            if (!btn_l && !btn_r) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         dir          <= 1'b0;
         frame_cnt    <= '0;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         jump_q       <= 1'b0;
      end else begin
         state        <= state_n;
         dir          <= dir_n;
         frame_cnt    <= frame_cnt_n;
         move_left_q  <= move_left_n;
         move_right_q <= move_right_n;
         jump_q       <= jump_n;
      end
   end

   assign bus.move_left     = move_left_q;
   assign bus.move_right    = move_right_q;
   assign bus.jump          = jump_q;
   assign bus.repeat_active = (state == REPEAT);

endmodule
